// File: rtl/sh7034_ibus_arb_pkg.sv
// Shared SH7034 internal-bus types: owner/state encoding, bus widths, the arbitration pick.
package sh7034_ibus_arb_pkg;

    localparam int A_W  = 28;
    localparam int D_W  = 32;
    localparam int BA_W = 4;

    // The FSM state doubles as the OWNER output encoding.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    function automatic owner_e arb_pick(input logic cpu_req, input logic dma_req,
                                        input logic cpu_starved, input logic dma_first);
        if (cpu_req && dma_req) begin
            return (cpu_starved || !dma_first) ? OWN_CPU : OWN_DMA;
        end
        if (dma_req) return OWN_DMA;
        if (cpu_req) return OWN_CPU;
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/sh7034_ibus_arb_if.sv
// CPU/DMAC master ports, shared internal bus and slave returns seen by the arbiter.
interface sh7034_ibus_arb_if;
    import sh7034_ibus_arb_pkg::*;

    logic [A_W-1:0]  CPU_A,   DMA_A,   IBUS_A;
    logic [D_W-1:0]  CPU_DI,  DMA_DI,  IBUS_DO;
    logic [BA_W-1:0] CPU_BA,  DMA_BA,  IBUS_BA;
    logic            CPU_WE,  DMA_WE,  IBUS_WE;
    logic            CPU_REQ, DMA_REQ, IBUS_REQ;
    logic [D_W-1:0]  CPU_DO,  DMA_DO;
    logic            CPU_BUSY, DMA_BUSY;
    logic [D_W-1:0]  RAM_DI,  PER_DI,  BSC_DI;
    logic            RAM_BUSY, PER_BUSY, BSC_BUSY;
    logic            RAM_ACT, PER_ACT, BSC_ACT;
    logic [1:0]      OWNER;
    logic            ADDR_ERR;

    modport slave (
        input  CPU_A, CPU_DI, CPU_BA, CPU_WE, CPU_REQ,
        input  DMA_A, DMA_DI, DMA_BA, DMA_WE, DMA_REQ,
        input  RAM_DI, PER_DI, BSC_DI, RAM_BUSY, PER_BUSY, BSC_BUSY,
        input  RAM_ACT, PER_ACT, BSC_ACT,
        output CPU_DO, CPU_BUSY, DMA_DO, DMA_BUSY,
        output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ, OWNER, ADDR_ERR
    );

    modport master (
        output CPU_A, CPU_DI, CPU_BA, CPU_WE, CPU_REQ,
        output DMA_A, DMA_DI, DMA_BA, DMA_WE, DMA_REQ,
        output RAM_DI, PER_DI, BSC_DI, RAM_BUSY, PER_BUSY, BSC_BUSY,
        output RAM_ACT, PER_ACT, BSC_ACT,
        input  CPU_DO, CPU_BUSY, DMA_DO, DMA_BUSY,
        input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ, OWNER, ADDR_ERR
    );

endinterface

// File: rtl/sh7034_ibus_arb.sv
// CPU/DMAC internal-bus arbiter with DMAC starvation limit; outputs combinational, zero added latency.
// Owner held while the selected slave stalls; non-owning requester sees BUSY until granted.
module sh7034_ibus_arb
    import sh7034_ibus_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter bit DMA_FIRST  = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              CE_F,
    sh7034_ibus_arb_if.slave  bus
);

    localparam int CNT_W = (STARVE_MAX > 7) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    owner_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic             own_req, any_act, sel_busy, xfer_ok, cpu_done, dma_done;
    logic [D_W-1:0]   sel_di;
    logic             ce_f_unused;

    assign ce_f_unused = CE_F;

    always_comb begin
        sel_busy = 1'b0;
        sel_di   = '0;
        any_act  = 1'b1;
        if (bus.RAM_ACT) begin
            sel_busy = bus.RAM_BUSY;
            sel_di   = bus.RAM_DI;
        end else if (bus.PER_ACT) begin
            sel_busy = bus.PER_BUSY;
            sel_di   = bus.PER_DI;
        end else if (bus.BSC_ACT) begin
            sel_busy = bus.BSC_BUSY;
            sel_di   = bus.BSC_DI;
        end else begin
            any_act  = 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            OWN_CPU: own_req = bus.CPU_REQ;
            OWN_DMA: own_req = bus.DMA_REQ;
            default: own_req = 1'b0;
        endcase
    end

    // An unmapped access never stalls: sel_busy is 0 when no slave claims it.
    assign xfer_ok  = CE_R & own_req & ~sel_busy;
    assign cpu_done = xfer_ok & (state_q == OWN_CPU);
    assign dma_done = xfer_ok & (state_q == OWN_DMA);

    always_comb begin
        bus.IBUS_A   = '0;
        bus.IBUS_DO  = '0;
        bus.IBUS_BA  = '0;
        bus.IBUS_WE  = 1'b0;
        bus.IBUS_REQ = 1'b0;
        case (state_q)
            OWN_CPU: begin
                bus.IBUS_A   = bus.CPU_A;
                bus.IBUS_DO  = bus.CPU_DI;
                bus.IBUS_BA  = bus.CPU_BA;
                bus.IBUS_WE  = bus.CPU_WE;
                bus.IBUS_REQ = bus.CPU_REQ;
            end
            OWN_DMA: begin
                bus.IBUS_A   = bus.DMA_A;
                bus.IBUS_DO  = bus.DMA_DI;
                bus.IBUS_BA  = bus.DMA_BA;
                bus.IBUS_WE  = bus.DMA_WE;
                bus.IBUS_REQ = bus.DMA_REQ;
            end
            default: ;
        endcase
    end

    assign bus.CPU_DO   = sel_di;
    assign bus.DMA_DO   = sel_di;
    assign bus.CPU_BUSY = bus.CPU_REQ & ~cpu_done;
    assign bus.DMA_BUSY = bus.DMA_REQ & ~dma_done;
    assign bus.OWNER    = state_q;
    assign bus.ADDR_ERR = CE_R & own_req & ~any_act;

    // Arbitration after a completion sees the updated starvation count, so the
    // CPU wins the grant that immediately follows the STARVE_MAX-th DMAC transfer.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (CE_R) begin
            if (!bus.CPU_REQ || cpu_done) begin
                starve_d = '0;
            end else if (dma_done && (starve_q < CNT_MAX)) begin
                starve_d = starve_q + CNT_W'(1);
            end
            case (state_q)
                OWN_NONE: state_d = arb_pick(bus.CPU_REQ, bus.DMA_REQ,
                                             starve_d >= CNT_MAX, DMA_FIRST);
                default: begin
                    if (!own_req) begin
                        state_d = OWN_NONE;
                    end else if (!sel_busy) begin
                        state_d = arb_pick(bus.CPU_REQ, bus.DMA_REQ,
                                           starve_d >= CNT_MAX, DMA_FIRST);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule
